dmem_lsu_ctrl: RTL and testbench

DMEM_LSU_CTRL -- requirements
Module: dmem_lsu_ctrl

---
 rtl/dmem_lsu_pkg.sv | 30 +++
 rtl/dmem_lsu_ctrl_load_align.sv | 28 ++
 rtl/dmem_lsu_ctrl.sv | 152 +++++++++++++++
 tb/tb_dmem_lsu_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_lsu_pkg.sv
// Shared constants for the data-memory load/store unit: RV32I width codes,
// FSM state encoding and a legality helper for funct3.
package dmem_lsu_pkg;

  localparam int STATE_W = 2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 2'd0,
    LD_DATA = 2'd1,
    RMW_WR  = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Stores only know the signed width codes; loads also accept BU/HU.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!we) begin
      ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    end
    return ok;
  endfunction

endpackage

// File: rtl/dmem_lsu_ctrl_load_align.sv
// Combinational load alignment: picks the addressed byte/halfword lane of a
// memory word and sign- or zero-extends it according to funct3.
module lsu_load_align
  import dmem_lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'h000000, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'h0000, half_sel};
      F3_W:    data = word;
      default: data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// Load/store unit for a word-wide data memory with 1-cycle registered read.
// Sub-word stores use read-modify-write. Optional define MISALIGN_TRAP_EN
// turns misaligned halfword/word accesses into access faults.
module dmem_lsu_ctrl
  import dmem_lsu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_we,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_raddr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_t      state, state_next;
  logic [31:0] word_q, wdata_q;
  logic [3:0]  mask_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic        err_q;

  logic [31:0] word_addr;
  logic        accept;
  logic        misalign;
  logic        req_err;
  logic [31:0] st_data;
  logic [3:0]  st_mask;
  logic [31:0] merged;
  logic [31:0] align_data;

  assign word_addr = (req_addr - BASE_ADDR) & 32'hFFFF_FFFC;
  // Ready is forced low while reset is held even though state already reads IDLE.
  assign req_ready = rst_n && (state == IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
`ifdef MISALIGN_TRAP_EN
    misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
               ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    req_err = !f3_legal(req_we, req_funct3) || misalign;
  end

  always_comb begin
    st_data = req_wdata;
    st_mask = 4'b1111;
    if (req_funct3[1:0] == 2'b00) begin
      st_data = {4{req_wdata[7:0]}};
      st_mask = 4'b0001 << req_addr[1:0];
    end else if (req_funct3[1:0] == 2'b01) begin
      st_data = {2{req_wdata[15:0]}};
      st_mask = req_addr[1] ? 4'b1100 : 4'b0011;
    end
  end

  always_comb begin
    merged = mem_rdata;
    for (int i = 0; i < 4; i++) begin
      if (mask_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  lsu_load_align u_align (
    .word   (mem_rdata),
    .funct3 (funct3_q),
    .offset (off_q),
    .data   (align_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      word_q   <= 32'h0000_0000;
      wdata_q  <= 32'h0000_0000;
      mask_q   <= 4'b0000;
      funct3_q <= 3'b000;
      off_q    <= 2'b00;
      err_q    <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        word_q   <= word_addr;
        wdata_q  <= st_data;
        mask_q   <= st_mask;
        funct3_q <= req_funct3;
        off_q    <= req_addr[1:0];
        err_q    <= req_err;
      end
    end
  end

  always_comb begin
    state_next = state;
    mem_we     = 1'b0;
    mem_wdata  = 32'h0000_0000;
    mem_raddr  = word_q;
    mem_waddr  = word_q;
    rsp_valid  = 1'b0;
    rsp_err    = 1'b0;
    rsp_rdata  = 32'h0000_0000;
    case (state)
      IDLE: begin
        mem_raddr = word_addr;
        mem_waddr = word_addr;
        if (accept) begin
          if (req_err) begin
            state_next = ST_RESP;
          end else if (!req_we) begin
            state_next = LD_DATA;
          end else if (req_funct3 == F3_W) begin
            mem_we     = 1'b1;
            mem_wdata  = req_wdata;
            state_next = ST_RESP;
          end else begin
            state_next = RMW_WR;
          end
        end
      end
      LD_DATA: begin
        rsp_valid  = 1'b1;
        rsp_rdata  = align_data;
        state_next = IDLE;
      end
      RMW_WR: begin
        mem_we     = 1'b1;
        mem_wdata  = merged;
        state_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid  = 1'b1;
        rsp_err    = err_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Directed self-checking bench for dmem_lsu_ctrl with a small word memory
// model providing a 1-cycle registered read.
module tb_dmem_lsu_ctrl;
  import dmem_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_we;
  logic [31:0] mem_waddr, mem_raddr, mem_wdata, mem_rdata;

  logic [31:0] mem [16];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_lsu_ctrl #(.BASE_ADDR(32'h0000_0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_raddr  (mem_raddr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always @(posedge clk) begin
    mem_rdata <= mem[mem_raddr[5:2]];
    if (mem_we) mem[mem_waddr[5:2]] <= mem_wdata;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
  endtask

  task automatic nextCycle(input logic drop_valid);
    @(posedge clk);
    #1;
    if (drop_valid) req_valid = 1'b0;
  endtask

  // Single request answered in T+1 (loads, SW, faults); mem_we expected only for SW.
  task automatic oneCycleOp(input string tag, input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic exp_we, input logic [31:0] exp_rdata,
                            input logic exp_err);
    applyStimulus(we, f3, addr, wdata);
    @(negedge clk);
    checkOutput({tag, ".ready_T"}, 32'(req_ready), 32'd1);
    checkOutput({tag, ".we_T"}, 32'(mem_we), 32'(exp_we));
    if (exp_we) begin
      checkOutput({tag, ".waddr_T"}, mem_waddr, addr & 32'hFFFF_FFFC);
      checkOutput({tag, ".wdata_T"}, mem_wdata, wdata);
    end
    nextCycle(1'b1);
    @(negedge clk);
    checkOutput({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    checkOutput({tag, ".rdata"}, rsp_rdata, exp_rdata);
    checkOutput({tag, ".err"}, 32'(rsp_err), 32'(exp_err));
    checkOutput({tag, ".we_T1"}, 32'(mem_we), 32'd0);
    nextCycle(1'b0);
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst.ready", 32'(req_ready), 32'd0);
    checkOutput("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst.err", 32'(rsp_err), 32'd0);
    checkOutput("rst.rdata", rsp_rdata, 32'h0);
    checkOutput("rst.we", 32'(mem_we), 32'd0);

    // Preload memory through SW, the first accepted right after reset release
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    oneCycleOp("sw10", 1'b1, F3_W, 32'h10, 32'h0000_1000, 1'b1, 32'h0, 1'b0);
    oneCycleOp("sw0c", 1'b1, F3_W, 32'h0C, 32'h0000_0100, 1'b1, 32'h0, 1'b0);

    oneCycleOp("lw10", 1'b0, F3_W, 32'h10, 32'h0, 1'b0, 32'h0000_1000, 1'b0);

    // SB 0x0D: read-modify-write
    applyStimulus(1'b1, F3_B, 32'h0D, 32'h0000_00AB);
    @(negedge clk);
    checkOutput("sb.we_T", 32'(mem_we), 32'd0);
    nextCycle(1'b1);
    @(negedge clk);
    checkOutput("sb.we_T1", 32'(mem_we), 32'd1);
    checkOutput("sb.waddr_T1", mem_waddr, 32'h0000_000C);
    checkOutput("sb.wdata_T1", mem_wdata, 32'h0000_AB00);
    checkOutput("sb.rsp_T1", 32'(rsp_valid), 32'd0);
    checkOutput("sb.ready_T1", 32'(req_ready), 32'd0);
    nextCycle(1'b0);
    @(negedge clk);
    checkOutput("sb.rsp_T2", 32'(rsp_valid), 32'd1);
    checkOutput("sb.err_T2", 32'(rsp_err), 32'd0);
    checkOutput("sb.we_T2", 32'(mem_we), 32'd0);
    nextCycle(1'b0);

    oneCycleOp("lw0c", 1'b0, F3_W, 32'h0C, 32'h0, 1'b0, 32'h0000_AB00, 1'b0);
    oneCycleOp("lb0d", 1'b0, F3_B, 32'h0D, 32'h0, 1'b0, 32'hFFFF_FFAB, 1'b0);
    oneCycleOp("lbu0d", 1'b0, F3_BU, 32'h0D, 32'h0, 1'b0, 32'h0000_00AB, 1'b0);
    oneCycleOp("lh0c", 1'b0, F3_H, 32'h0C, 32'h0, 1'b0, 32'hFFFF_AB00, 1'b0);
    oneCycleOp("lhu0c", 1'b0, F3_HU, 32'h0C, 32'h0, 1'b0, 32'h0000_AB00, 1'b0);

`ifdef MISALIGN_TRAP_EN
    oneCycleOp("lh11", 1'b0, F3_H, 32'h11, 32'h0, 1'b0, 32'h0, 1'b1);
`else
    oneCycleOp("lh11", 1'b0, F3_H, 32'h11, 32'h0, 1'b0, 32'h0000_1000, 1'b0);
`endif

    // SH 0x0E aborted by reset during T+1
    applyStimulus(1'b1, F3_H, 32'h0E, 32'h0000_1234);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    checkOutput("shrst.we", 32'(mem_we), 32'd0);
    checkOutput("shrst.rsp", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("shrst.rsp_after", 32'(rsp_valid), 32'd0);
    checkOutput("shrst.we_after", 32'(mem_we), 32'd0);
    nextCycle(1'b0);
    oneCycleOp("lw0c_old", 1'b0, F3_W, 32'h0C, 32'h0, 1'b0, 32'h0000_AB00, 1'b0);

    // Back-to-back LWs with req_valid held high
    applyStimulus(1'b0, F3_W, 32'h10, 32'h0);
    @(negedge clk);
    checkOutput("b2b.ready_T", 32'(req_ready), 32'd1);
    nextCycle(1'b0);
    req_addr = 32'h0C;
    @(negedge clk);
    checkOutput("b2b.ready_T1", 32'(req_ready), 32'd0);
    checkOutput("b2b.rsp_T1", 32'(rsp_valid), 32'd1);
    checkOutput("b2b.rdata_T1", rsp_rdata, 32'h0000_1000);
    nextCycle(1'b0);
    @(negedge clk);
    checkOutput("b2b.ready_T2", 32'(req_ready), 32'd1);
    checkOutput("b2b.rsp_T2", 32'(rsp_valid), 32'd0);
    nextCycle(1'b1);
    @(negedge clk);
    checkOutput("b2b.rsp_T3", 32'(rsp_valid), 32'd1);
    checkOutput("b2b.rdata_T3", rsp_rdata, 32'h0000_AB00);
    nextCycle(1'b0);
    @(negedge clk);
    checkOutput("b2b.rsp_T4", 32'(rsp_valid), 32'd0);
    nextCycle(1'b0);

    // Illegal width codes
    oneCycleOp("ld011", 1'b0, 3'b011, 32'h10, 32'h0, 1'b0, 32'h0, 1'b1);
    oneCycleOp("st100", 1'b1, 3'b100, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1);
    oneCycleOp("lw10_chk", 1'b0, F3_W, 32'h10, 32'h0, 1'b0, 32'h0000_1000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
